// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle for XLEN cycles, valid/ready on both sides with a passthrough tag.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             neg_a;
    logic             neg_b;
    logic [XLEN:0]    hi;
    logic [XLEN-1:0]  lo;
    logic [CNT_W-1:0] cnt;

    logic             a_signed_in;
    logic             b_signed_in;
    logic             sa_in;
    logic             sb_in;
    logic [XLEN-1:0]  a_abs_in;
    logic [XLEN-1:0]  b_abs_in;

    always_comb begin
        a_signed_in = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        b_signed_in = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        sa_in       = a_signed_in && in_a[XLEN-1];
        sb_in       = b_signed_in && in_b[XLEN-1];
        a_abs_in    = sa_in ? (~in_a + 1'b1) : in_a;
        b_abs_in    = sb_in ? (~in_b + 1'b1) : in_b;
    end

    // Multiply: hi accumulates, lo shifts the multiplier out LSB first and the product low half in.
    // Divide: lo shifts the dividend out MSB first and the quotient in; hi is the partial remainder.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN:0]   hi_nxt;
    logic [XLEN-1:0] lo_nxt;

    always_comb begin
        mul_sum   = hi + {1'b0, (lo[0] ? a_mag : {XLEN{1'b0}})};
        div_shift = {hi[XLEN-1:0], lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        hi_nxt    = {1'b0, mul_sum[XLEN:1]};
        lo_nxt    = {mul_sum[0], lo[XLEN-1:1]};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_nxt = div_diff;
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift;
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   a_orig;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   result;

    always_comb begin
        prod     = {hi_nxt[XLEN-1:0], lo_nxt};
        prod_s   = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
        quo_s    = (neg_a ^ neg_b) ? (~lo_nxt + 1'b1) : lo_nxt;
        rem_s    = neg_a ? (~hi_nxt[XLEN-1:0] + 1'b1) : hi_nxt[XLEN-1:0];
        a_orig   = neg_a ? (~a_mag + 1'b1) : a_mag;
        div_zero = (b_mag == '0);
        div_ovf  = neg_a && neg_b && (a_mag == {1'b1, {(XLEN-1){1'b0}}})
                   && (b_mag == {{(XLEN-1){1'b0}}, 1'b1});
        case (op_q)
            3'd0:       result = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       result = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: result = div_zero ? {XLEN{1'b1}} : (div_ovf ? a_orig : quo_s);
            default:    result = div_zero ? a_orig : (div_ovf ? {XLEN{1'b0}} : rem_s);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            cnt        <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            a_mag      <= '0;
            b_mag      <= '0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        op_q     <= in_op;
                        tag_q    <= in_tag;
                        a_mag    <= a_abs_in;
                        b_mag    <= b_abs_in;
                        neg_a    <= sa_in;
                        neg_b    <= sb_in;
                        hi       <= '0;
                        lo       <= in_op[2] ? a_abs_in : b_abs_in;
                        cnt      <= CNT_W'(XLEN);
                    end
                end
                BUSY: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        out_result <= result;
                        out_tag    <= tag_q;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed RV32M results, latency, backpressure,
// flush and asynchronous reset.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = 5'd31;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        int lat;
        issue(name, op, a, b, tag);
        wait_result(lat);
        check({name, " latency"}, 32'(lat), 32'd33);
        check(name, out_result, exp);
        check({name, " tag"}, {27'd0, out_tag}, {27'd0, tag});
        @(posedge clk);
        #1;
        check({name, " handshake"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] held_res;
        logic [4:0]  held_tag;

        #12;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_tag", {27'd0, out_tag}, 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul",        3'd0, 32'd7,         32'd6,         5'd3,  32'd42);
        run_op("mulh",       3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000);
        run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF);
        run_op("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE);
        run_op("div",        3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD);
        run_op("rem",        3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF);
        run_op("divu",       3'd5, 32'd100,       32'd7,         5'd9,  32'd14);
        run_op("remu",       3'd7, 32'd100,       32'd7,         5'd10, 32'd2);
        run_op("div by 0",   3'd4, 32'd123,       32'd0,         5'd11, 32'hFFFF_FFFF);
        run_op("remu by 0",  3'd7, 32'd5,         32'd0,         5'd12, 32'd5);
        run_op("div ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run_op("rem ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);

        // Backpressure
        out_ready = 1'b0;
        issue("bp", 3'd0, 32'd1000, 32'd1000, 5'd21);
        wait_result(lat);
        check("bp latency", 32'(lat), 32'd33);
        check("bp result", out_result, 32'd1_000_000);
        held_res = out_result;
        held_tag = out_tag;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp hold result", out_result, held_res);
            check("bp hold tag", {27'd0, out_tag}, {27'd0, held_tag});
            check("bp hold valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp single handshake", {30'd0, out_valid, in_ready}, 32'd1);

        // Flush during iteration 10
        issue("fl", 3'd5, 32'd999, 32'd3, 5'd17);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        check("flush holds result", out_result, 32'd1_000_000);
        check("flush holds tag", {27'd0, out_tag}, 32'd21);
        run_op("after flush", 3'd5, 32'd999, 32'd3, 5'd18, 32'd333);

        // Asynchronous reset mid-BUSY
        issue("rst", 3'd0, 32'd3, 32'd3, 5'd19);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async rst in_ready", {31'd0, in_ready}, 32'd1);
        check("async rst out_valid", {31'd0, out_valid}, 32'd0);
        check("async rst out_result", out_result, 32'd0);
        check("async rst out_tag", {27'd0, out_tag}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after reset", 3'd6, 32'd17, 32'hFFFF_FFFB, 5'd20, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
